// File: rtl/issue_scheduler_pkg.sv
// Shared types and defaults for the issue scheduler.
// The ROB depth comes from the `RobDepth macro; it defaults to 16 when the macro is not defined.
`ifndef RobDepth
`define RobDepth 16
`endif

package issue_scheduler_pkg;

  localparam int DEPTH_DEF     = 8;
  localparam int ROB_DEPTH_DEF = `RobDepth;
  localparam int ROB_W         = $clog2(ROB_DEPTH_DEF);

  typedef struct packed {
    logic             valid;
    logic [ROB_W-1:0] rob_id;
    logic             rs1_wait;
    logic [ROB_W-1:0] rs1_tag;
    logic             rs2_wait;
    logic [ROB_W-1:0] rs2_tag;
  } sched_entry_t;

  function automatic logic bc_match(input logic [ROB_W-1:0] tag, input logic bc_v,
                                    input logic [ROB_W-1:0] bc_id);
    return bc_v && (tag == bc_id);
  endfunction

endpackage

// File: rtl/issue_scheduler_oldest_ready_sel.sv
// Age matrix for the scheduler: older_q[i][j]=1 means entry j is older than entry i.
// Produces the one-hot select of the oldest ready entry.
module issue_scheduler_oldest_ready_sel #(
  parameter int DEPTH = 8,
  parameter int ENT   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             clear,
  input  logic [DEPTH-1:0] valid_vec,
  input  logic [DEPTH-1:0] ready_vec,
  input  logic             alloc_en,
  input  logic [ENT-1:0]   alloc_idx,
  input  logic             free_en,
  output logic [DEPTH-1:0] sel_oh,
  output logic             any_ready
);

  logic [DEPTH-1:0] older_q [DEPTH];
  logic [DEPTH-1:0] older_d [DEPTH];

  always_comb begin
    sel_oh    = '0;
    any_ready = |ready_vec;
    for (int i = 0; i < DEPTH; i++) begin
      sel_oh[i] = ready_vec[i] && !(|(older_q[i] & ready_vec));
    end
  end

  // New row records every live entry as older; the freed column is then cleared everywhere.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      older_d[i] = older_q[i];
      if (alloc_en && (alloc_idx == ENT'(i))) older_d[i] = valid_vec;
      if (free_en) older_d[i] = older_d[i] & ~sel_oh;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (clear) older_q[i] <= '0;
      else       older_q[i] <= older_d[i];
    end
  end

endmodule

// File: rtl/issue_scheduler.sv
// Reservation-station scheduler: holds dispatched ops, wakes operands on broadcasts, issues oldest ready.
// Optional feature macro: ISSUE_SCHED_COMMIT_WAKEUP_EN (commit broadcast also wakes operands).
module issue_scheduler
  import issue_scheduler_pkg::*;
#(
  parameter  int DEPTH     = DEPTH_DEF,
  parameter  int ROB_DEPTH = ROB_DEPTH_DEF,
  localparam int ROB       = $clog2(ROB_DEPTH),
  localparam int ENT       = $clog2(DEPTH)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           flush,
  input  logic           disp_e_,
  input  logic [ROB-1:0] disp_rob_id,
  input  logic           disp_rs1_wait,
  input  logic [ROB-1:0] disp_rs1_tag,
  input  logic           disp_rs2_wait,
  input  logic [ROB-1:0] disp_rs2_tag,
  output logic           disp_busy,
  input  logic           wb_e_,
  input  logic [ROB-1:0] wb_rob_id,
  input  logic           commit_e_,
  input  logic [ROB-1:0] commit_rob_id,
  output logic           issue_e_,
  output logic [ROB-1:0] issue_rob_id,
  input  logic           issue_stall
);

  sched_entry_t     ent_q [DEPTH];
  sched_entry_t     ent_d [DEPTH];
  logic [DEPTH-1:0] valid_vec, ready_vec, sel_oh;
  logic             any_ready, fire, alloc_en, has_free;
  logic             disp_busy_q, disp_busy_d;
  logic [ENT-1:0]   alloc_idx;
  logic             wb_v, cm_v;
  logic [ROB-1:0]   cm_id;

  assign wb_v = !wb_e_;

`ifdef ISSUE_SCHED_COMMIT_WAKEUP_EN
  assign cm_v  = !commit_e_;
  assign cm_id = commit_rob_id;
`else
  logic unused_commit;
  assign unused_commit = ^{commit_e_, commit_rob_id};
  assign cm_v  = 1'b0;
  assign cm_id = '0;
`endif

  always_comb begin
    valid_vec = '0;
    ready_vec = '0;
    for (int i = 0; i < DEPTH; i++) begin
      valid_vec[i] = ent_q[i].valid;
      ready_vec[i] = ent_q[i].valid && !ent_q[i].rs1_wait && !ent_q[i].rs2_wait;
    end
  end

  // Lowest-index free slot; scanning downward lets the lowest index win.
  always_comb begin
    has_free  = 1'b0;
    alloc_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!valid_vec[i]) begin
        has_free  = 1'b1;
        alloc_idx = ENT'(i);
      end
    end
  end

  assign alloc_en = !disp_e_ && !disp_busy_q && has_free;
  assign fire     = any_ready && !issue_stall;

  issue_scheduler_oldest_ready_sel #(.DEPTH(DEPTH), .ENT(ENT)) u_sel (
    .clk       (clk),
    .clear     (reset || flush),
    .valid_vec (valid_vec),
    .ready_vec (ready_vec),
    .alloc_en  (alloc_en),
    .alloc_idx (alloc_idx),
    .free_en   (fire),
    .sel_oh    (sel_oh),
    .any_ready (any_ready)
  );

  always_comb begin
    issue_rob_id = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (sel_oh[i]) issue_rob_id = issue_rob_id | ent_q[i].rob_id;
    end
  end

  assign issue_e_  = !any_ready;
  assign disp_busy = disp_busy_q;

  always_comb begin
    disp_busy_d = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      ent_d[i] = ent_q[i];
      if (ent_q[i].rs1_wait && (bc_match(ent_q[i].rs1_tag, wb_v, wb_rob_id) ||
                                bc_match(ent_q[i].rs1_tag, cm_v, cm_id)))
        ent_d[i].rs1_wait = 1'b0;
      if (ent_q[i].rs2_wait && (bc_match(ent_q[i].rs2_tag, wb_v, wb_rob_id) ||
                                bc_match(ent_q[i].rs2_tag, cm_v, cm_id)))
        ent_d[i].rs2_wait = 1'b0;
      if (fire && sel_oh[i]) ent_d[i].valid = 1'b0;
      // A tag broadcast in the dispatch cycle is captured as already available.
      if (alloc_en && (alloc_idx == ENT'(i))) begin
        ent_d[i].valid    = 1'b1;
        ent_d[i].rob_id   = disp_rob_id;
        ent_d[i].rs1_tag  = disp_rs1_tag;
        ent_d[i].rs2_tag  = disp_rs2_tag;
        ent_d[i].rs1_wait = disp_rs1_wait && !bc_match(disp_rs1_tag, wb_v, wb_rob_id)
                                          && !bc_match(disp_rs1_tag, cm_v, cm_id);
        ent_d[i].rs2_wait = disp_rs2_wait && !bc_match(disp_rs2_tag, wb_v, wb_rob_id)
                                          && !bc_match(disp_rs2_tag, cm_v, cm_id);
      end
      disp_busy_d = disp_busy_d && ent_d[i].valid;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
      disp_busy_q <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= ent_d[i];
      disp_busy_q <= disp_busy_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && !flush && !disp_e_)
      assert (!disp_busy_q) else $warning("issue_scheduler: dispatch ignored while disp_busy");
  end

endmodule

// File: tb/tb_issue_scheduler.sv
// Self-checking bench for issue_scheduler: directed scenarios then random traffic,
// compared against an age-ordered queue model of the scheduler.
module tb_issue_scheduler;
  import issue_scheduler_pkg::*;

  localparam int DEPTH = DEPTH_DEF;
  localparam int ROB   = ROB_W;

  logic           clk = 1'b0;
  logic           reset, flush, disp_e_, disp_rs1_wait, disp_rs2_wait, disp_busy;
  logic [ROB-1:0] disp_rob_id, disp_rs1_tag, disp_rs2_tag;
  logic           wb_e_, commit_e_, issue_e_, issue_stall;
  logic [ROB-1:0] wb_rob_id, commit_rob_id, issue_rob_id;

  issue_scheduler dut (
    .clk           (clk),
    .reset         (reset),
    .flush         (flush),
    .disp_e_       (disp_e_),
    .disp_rob_id   (disp_rob_id),
    .disp_rs1_wait (disp_rs1_wait),
    .disp_rs1_tag  (disp_rs1_tag),
    .disp_rs2_wait (disp_rs2_wait),
    .disp_rs2_tag  (disp_rs2_tag),
    .disp_busy     (disp_busy),
    .wb_e_         (wb_e_),
    .wb_rob_id     (wb_rob_id),
    .commit_e_     (commit_e_),
    .commit_rob_id (commit_rob_id),
    .issue_e_      (issue_e_),
    .issue_rob_id  (issue_rob_id),
    .issue_stall   (issue_stall)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- reference model: queue kept oldest-first ----------------
  typedef struct {
    int rob;
    bit w1;
    int t1;
    bit w2;
    int t2;
  } m_ent_t;

  m_ent_t         mq[$];
  logic [ROB-1:0] exp_q[$];
  int             total = 0;
  int             bad   = 0;

  function automatic bit m_hit(int tag);
    bit cm;
`ifdef ISSUE_SCHED_COMMIT_WAKEUP_EN
    cm = (commit_e_ == 1'b0) && (tag == int'(commit_rob_id));
`else
    cm = 1'b0;
`endif
    return ((wb_e_ == 1'b0) && (tag == int'(wb_rob_id))) || cm;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_update(input bit found, input int idx);
    bit     pre_full;
    m_ent_t e;
    if (reset || flush) begin
      mq.delete();
      return;
    end
    pre_full = (mq.size() == DEPTH);
    if (found && !issue_stall) mq.delete(idx);
    foreach (mq[k]) begin
      if (mq[k].w1 && m_hit(mq[k].t1)) mq[k].w1 = 1'b0;
      if (mq[k].w2 && m_hit(mq[k].t2)) mq[k].w2 = 1'b0;
    end
    if (!disp_e_ && !pre_full) begin
      e.rob = int'(disp_rob_id);
      e.t1  = int'(disp_rs1_tag);
      e.t2  = int'(disp_rs2_tag);
      e.w1  = disp_rs1_wait && !m_hit(e.t1);
      e.w2  = disp_rs2_wait && !m_hit(e.t2);
      mq.push_back(e);
    end
  endtask

  // One clock: check outputs mid-cycle, then advance the model at the edge.
  task automatic cyc();
    bit             found;
    int             idx;
    logic [ROB-1:0] exp_id, got;
    #2;
    found  = 1'b0;
    idx    = 0;
    for (int k = 0; k < mq.size(); k++) begin
      if (!mq[k].w1 && !mq[k].w2) begin
        found = 1'b1;
        idx   = k;
        break;
      end
    end
    exp_id = found ? ROB'(mq[idx].rob) : '0;
    chk("issue_e_", 32'(issue_e_), 32'(!found));
    chk("issue_rob_id", 32'(issue_rob_id), 32'(exp_id));
    chk("disp_busy", 32'(disp_busy), 32'(mq.size() == DEPTH));
    if (found && !issue_stall && !reset && !flush) exp_q.push_back(exp_id);
    if (issue_e_ === 1'b0 && !issue_stall && !reset && !flush) begin
      if (exp_q.size() == 0) begin
        chk("issue_extra", 32'(issue_rob_id), 32'hffff_ffff);
      end else begin
        got = exp_q.pop_front();
        chk("issue_order", 32'(issue_rob_id), 32'(got));
      end
    end
    @(posedge clk);
    model_update(found, idx);
    #1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_idle();
    reset         = 1'b0;
    flush         = 1'b0;
    disp_e_       = 1'b1;
    disp_rob_id   = '0;
    disp_rs1_wait = 1'b0;
    disp_rs1_tag  = '0;
    disp_rs2_wait = 1'b0;
    disp_rs2_tag  = '0;
    wb_e_         = 1'b1;
    wb_rob_id     = '0;
    commit_e_     = 1'b1;
    commit_rob_id = '0;
    issue_stall   = 1'b0;
  endtask

  task automatic disp(input int rob, input bit w1, input int t1, input bit w2, input int t2);
    disp_e_       = 1'b0;
    disp_rob_id   = ROB'(rob);
    disp_rs1_wait = w1;
    disp_rs1_tag  = ROB'(t1);
    disp_rs2_wait = w2;
    disp_rs2_tag  = ROB'(t2);
  endtask

  task automatic wb(input int id);
    wb_e_     = 1'b0;
    wb_rob_id = ROB'(id);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    set_idle();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (2) cyc();

    // single ready op issues the next cycle
    disp(3, 0, 0, 0, 0); cyc();
    set_idle(); repeat (2) cyc();

    // younger ready op issues before older waiting op; wakeup then issues the older one
    disp(5, 1, 2, 0, 0); cyc();
    set_idle(); disp(6, 0, 0, 0, 0); cyc();
    set_idle(); wb(2); cyc();
    set_idle(); repeat (3) cyc();

    // same-cycle capture of a broadcast tag
    disp(7, 1, 4, 0, 0); wb(4); cyc();
    set_idle(); repeat (2) cyc();

    // fill, dropped dispatch, no credit for a same-cycle issue
    for (int i = 0; i < DEPTH; i++) begin
      set_idle(); disp(i, 0, 0, 1, 15); cyc();
    end
    set_idle(); disp(9, 0, 0, 0, 0); cyc();
    set_idle(); wb(15); cyc();
    set_idle(); disp(9, 0, 0, 0, 0); cyc();
    set_idle(); repeat (DEPTH + 2) cyc();

    // stall holds the issued op
    disp(1, 0, 0, 0, 0); cyc();
    set_idle(); issue_stall = 1'b1; repeat (3) cyc();
    issue_stall = 1'b0; repeat (2) cyc();

    // while stalled an older op becoming ready takes over the select
    disp(11, 1, 6, 0, 0); cyc();
    set_idle(); disp(12, 0, 0, 0, 0); cyc();
    set_idle(); issue_stall = 1'b1; cyc();
    wb(6); cyc();
    set_idle(); issue_stall = 1'b1; cyc();
    issue_stall = 1'b0; repeat (3) cyc();

    // flush with live entries and a same-cycle dispatch
    for (int i = 0; i < 4; i++) begin
      set_idle(); disp(i + 2, 1, 14, 0, 0); cyc();
    end
    set_idle(); disp(13, 0, 0, 0, 0); flush = 1'b1; cyc();
    set_idle(); repeat (2) cyc();

    // commit-only wakeup
    disp(8, 1, 0, 0, 0); cyc();
    set_idle(); commit_e_ = 1'b0; commit_rob_id = '0; cyc();
    set_idle(); repeat (3) cyc();
    flush = 1'b1; cyc();
    set_idle(); cyc();

    // random traffic
    for (int n = 0; n < 800; n++) begin
      set_idle();
      if ((mq.size() < DEPTH && $urandom_range(0, 2) != 0) || $urandom_range(0, 19) == 0)
        disp(int'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), int'($urandom_range(0, 7)),
             1'($urandom_range(0, 1)), int'($urandom_range(0, 7)));
      if ($urandom_range(0, 1) == 1) wb(int'($urandom_range(0, 7)));
      if ($urandom_range(0, 2) == 0) begin
        commit_e_     = 1'b0;
        commit_rob_id = ROB'($urandom_range(0, 7));
      end
      issue_stall = ($urandom_range(0, 3) == 0);
      flush       = ($urandom_range(0, 79) == 0);
      reset       = ($urandom_range(0, 199) == 0);
      cyc();
    end

    set_idle(); flush = 1'b1; cyc();
    set_idle(); repeat (2) cyc();
    chk("issue_missing", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
